// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin front end for a single-ported SRAM: one registered
// issue stage drives the SRAM, and a tag pipeline routes read data back to its issuer.
module sram_port_arbiter #(
  parameter int width         = 16,
  parameter int logDepth      = 9,
  parameter int logLineOffset = 3,
  parameter int readLatency   = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [1:0]                        reqValid,
  output logic [1:0]                        reqReady,
  input  logic [1:0]                        reqWrite,
  input  logic [2*logDepth-1:0]             reqAddr,
  input  logic [2*width-1:0]                reqData,
  input  logic [2*(1<<logLineOffset)-1:0]   reqMask,
  output logic [1:0]                        respValid,
  output logic [width-1:0]                  respData,
  output logic                              idle,
  output logic [width-1:0]                  sramWriteData,
  output logic [logDepth-1:0]               sramWriteAddr,
  output logic [(1<<logLineOffset)-1:0]     sramWriteEnable,
  output logic                              sramWriteConfirm,
  output logic [logDepth-1:0]               sramReadAddr,
  input  logic [width-1:0]                  sramReadData
);

  localparam int maskWidth = 1 << logLineOffset;

  typedef enum logic {PREFER0 = 1'b0, PREFER1 = 1'b1} rrState_t;
  rrState_t rrState, rrNext;

  logic [1:0]           grant;
  logic                 accept;
  logic                 grantId;
  logic                 selWrite;
  logic [logDepth-1:0]  selAddr;
  logic [width-1:0]     selData;
  logic [maskWidth-1:0] selMask;

  logic                 wrPending, wrPendingNext;
  logic [readLatency:0] tagValid, tagValidNext;
  logic [readLatency:0] tagId, tagIdNext;

  // Grant depends only on reqValid and the pointer, never on reqWrite.
  always_comb begin
    grant = '0;
    if (reqValid[0] && (!reqValid[1] || rrState == PREFER0)) begin
      grant[0] = 1'b1;
    end else if (reqValid[1]) begin
      grant[1] = 1'b1;
    end
    if (!reset_n) begin
      grant = '0;
    end
  end

  assign reqReady = grant;
  assign accept   = |grant;
  assign grantId  = grant[1];

  always_comb begin
    selWrite = reqWrite[0];
    selAddr  = reqAddr[0 +: logDepth];
    selData  = reqData[0 +: width];
    selMask  = reqMask[0 +: maskWidth];
    if (grantId) begin
      selWrite = reqWrite[1];
      selAddr  = reqAddr[logDepth +: logDepth];
      selData  = reqData[width +: width];
      selMask  = reqMask[maskWidth +: maskWidth];
    end
  end

  always_comb begin
    rrNext = rrState;
    if (accept) begin
      rrNext = grantId ? PREFER0 : PREFER1;
    end
    wrPendingNext = accept & selWrite;
    tagValidNext  = {tagValid[readLatency-1:0], accept & ~selWrite};
    tagIdNext     = {tagId[readLatency-1:0], grantId};
  end

  // idle is registered from the next-state values so it lines up with the pipeline contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rrState   <= PREFER0;
      wrPending <= 1'b0;
      tagValid  <= '0;
      tagId     <= '0;
      idle      <= 1'b1;
      respValid <= '0;
      respData  <= '0;
    end else begin
      rrState   <= rrNext;
      wrPending <= wrPendingNext;
      tagValid  <= tagValidNext;
      tagId     <= tagIdNext;
      idle      <= ~(|tagValidNext) & ~wrPendingNext;
      respValid <= '0;
      if (tagValid[readLatency]) begin
        respValid[tagId[readLatency]] <= 1'b1;
        respData                      <= sramReadData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sramWriteData    <= '0;
      sramWriteAddr    <= '0;
      sramWriteEnable  <= '0;
      sramWriteConfirm <= 1'b0;
      sramReadAddr     <= '0;
    end else begin
      sramWriteEnable  <= '0;
      sramWriteConfirm <= 1'b0;
      if (accept && selWrite) begin
        sramWriteData    <= selData;
        sramWriteAddr    <= selAddr;
        sramWriteEnable  <= selMask;
        sramWriteConfirm <= |selMask;
      end
      if (accept && !selWrite) begin
        sramReadAddr <= selAddr;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with behavioural SRAMs behind a default
// build and a readLatency=3 build; responses are checked against a scoreboard.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];
  exp_t eMon, eMon3;

  // default build signals
  logic [1:0]  reqValid, reqReady, reqWrite, respValid;
  logic [17:0] reqAddr;
  logic [31:0] reqData;
  logic [15:0] reqMask;
  logic [15:0] respData, sramWriteData, sramReadData;
  logic        idle, sramWriteConfirm;
  logic [8:0]  sramWriteAddr, sramReadAddr;
  logic [7:0]  sramWriteEnable;

  // readLatency=3 build signals
  logic [1:0]  reqValid3, reqReady3, reqWrite3, respValid3;
  logic [17:0] reqAddr3;
  logic [31:0] reqData3;
  logic [15:0] reqMask3;
  logic [15:0] respData3, sramWriteData3, sramReadData3;
  logic        idle3, sramWriteConfirm3;
  logic [8:0]  sramWriteAddr3, sramReadAddr3;
  logic [7:0]  sramWriteEnable3;

  sram_port_arbiter #(.width(16), .logDepth(9), .logLineOffset(3), .readLatency(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData), .reqMask(reqMask),
    .respValid(respValid), .respData(respData), .idle(idle),
    .sramWriteData(sramWriteData), .sramWriteAddr(sramWriteAddr),
    .sramWriteEnable(sramWriteEnable), .sramWriteConfirm(sramWriteConfirm),
    .sramReadAddr(sramReadAddr), .sramReadData(sramReadData)
  );

  sram_port_arbiter #(.width(16), .logDepth(9), .logLineOffset(3), .readLatency(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .reqValid(reqValid3), .reqReady(reqReady3), .reqWrite(reqWrite3),
    .reqAddr(reqAddr3), .reqData(reqData3), .reqMask(reqMask3),
    .respValid(respValid3), .respData(respData3), .idle(idle3),
    .sramWriteData(sramWriteData3), .sramWriteAddr(sramWriteAddr3),
    .sramWriteEnable(sramWriteEnable3), .sramWriteConfirm(sramWriteConfirm3),
    .sramReadAddr(sramReadAddr3), .sramReadData(sramReadData3)
  );

  function automatic logic [15:0] initWord(input logic [8:0] a);
    if (a == 9'h012) return 16'hBEEF;
    if (a == 9'h040) return 16'h1234;
    return 16'hA5C3 ^ {a[7:0], a[8:1] ^ 8'h3C};
  endfunction

  // 2-bit words, one mask bit per word
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [7:0] m);
    logic [15:0] r;
    r = old;
    for (int w = 0; w < 8; w++) if (m[w]) r[2*w +: 2] = d[2*w +: 2];
    return r;
  endfunction

  // Behavioural SRAMs: write on confirm, read data readLatency edges after address capture.
  logic [15:0] mem  [0:511];
  logic [15:0] mem3 [0:511];
  logic [15:0] refMem [0:511];
  logic [15:0] rdPipe;
  logic [15:0] rdPipe3 [0:2];
  bit loaded = 1'b0;
  bit loaded3 = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= initWord(9'(i));
      loaded <= 1'b1;
    end else if (sramWriteConfirm) begin
      mem[sramWriteAddr] <= merge(mem[sramWriteAddr], sramWriteData, sramWriteEnable);
    end
    rdPipe <= mem[sramReadAddr];
  end
  assign sramReadData = rdPipe;

  always @(posedge clk) begin
    if (!loaded3) begin
      for (int i = 0; i < 512; i++) mem3[i] <= initWord(9'(i));
      loaded3 <= 1'b1;
    end else if (sramWriteConfirm3) begin
      mem3[sramWriteAddr3] <= merge(mem3[sramWriteAddr3], sramWriteData3, sramWriteEnable3);
    end
    rdPipe3[0] <= mem3[sramReadAddr3];
    rdPipe3[1] <= rdPipe3[0];
    rdPipe3[2] <= rdPipe3[1];
  end
  assign sramReadData3 = rdPipe3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (respValid !== 2'b00) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'(respValid), 32'h0);
      end else begin
        eMon = sb.pop_front();
        check("resp_valid", 32'(respValid), 32'(eMon.v));
        check("resp_data", 32'(respData), 32'(eMon.d));
        check("resp_cycle", cyc, eMon.c);
      end
    end else if (sb.size() != 0 && sb[0].c < cyc) begin
      eMon = sb.pop_front();
      check("resp_missing_cycle", cyc, eMon.c);
    end
  end

  always @(negedge clk) begin
    if (respValid3 !== 2'b00) begin
      if (sb3.size() == 0) begin
        check("resp3_unexpected", 32'(respValid3), 32'h0);
      end else begin
        eMon3 = sb3.pop_front();
        check("resp3_valid", 32'(respValid3), 32'(eMon3.v));
        check("resp3_data", 32'(respData3), 32'(eMon3.d));
        check("resp3_cycle", cyc, eMon3.c);
      end
    end else if (sb3.size() != 0 && sb3[0].c < cyc) begin
      eMon3 = sb3.pop_front();
      check("resp3_missing_cycle", cyc, eMon3.c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic w, input logic [8:0] a,
                        input logic [15:0] d, input logic [7:0] m);
    reqValid[i] = v;
    reqWrite[i] = w;
    reqAddr[i*9 +: 9] = a;
    reqData[i*16 +: 16] = d;
    reqMask[i*8 +: 8] = m;
  endtask

  task automatic setReq3(input int i, input logic v, input logic [8:0] a);
    reqValid3[i] = v;
    reqWrite3[i] = 1'b0;
    reqAddr3[i*9 +: 9] = a;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (sb.size() != 0 || sb3.size() != 0); i++) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit rrModel;
    int c0, n0, n1;
    logic [1:0] expG;
    logic [8:0] a;

    reset_n   = 1'b0;
    reqValid  = '0; reqWrite  = '0; reqAddr  = '0; reqData  = '0; reqMask  = '0;
    reqValid3 = '0; reqWrite3 = '0; reqAddr3 = '0; reqData3 = '0; reqMask3 = '0;
    for (int i = 0; i < 512; i++) refMem[i] = initWord(9'(i));
    step(); step();

    // reset state, with both requesters asking
    setReq(0, 1'b1, 1'b0, 9'h001, 16'h0, 8'h0);
    setReq(1, 1'b1, 1'b0, 9'h002, 16'h0, 8'h0);
    @(negedge clk);
    check("reset_reqReady", 32'(reqReady), 32'h0);
    check("reset_idle", 32'(idle), 32'h1);
    check("reset_respValid", 32'(respValid), 32'h0);
    check("reset_confirm", 32'(sramWriteConfirm), 32'h0);
    check("reset_enable", 32'(sramWriteEnable), 32'h0);
    check("reset_readAddr", 32'(sramReadAddr), 32'h0);
    step();
    reqValid = '0;
    reset_n = 1'b1;
    rrModel = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(idle), 32'h1);
    step();

    // single read
    setReq(0, 1'b1, 1'b0, 9'h012, 16'h0, 8'h0);
    @(negedge clk);
    check("rd_ready", 32'(reqReady), 32'h1);
    sb.push_back('{v: 2'b01, d: refMem[9'h012], c: cyc + 3});
    rrModel = 1'b1;
    c0 = cyc;
    step();
    setReq(0, 1'b0, 1'b0, 9'h0, 16'h0, 8'h0);
    @(negedge clk);
    check("rd_sramReadAddr", 32'(sramReadAddr), 32'h012);
    check("rd_busy", 32'(idle), 32'h0);
    while (cyc < c0 + 4) step();
    @(negedge clk);
    check("rd_idle_after", 32'(idle), 32'h1);
    step();

    // partial write then back-to-back read of the same line
    setReq(1, 1'b1, 1'b1, 9'h040, 16'hFFFF, 8'h03);
    @(negedge clk);
    check("wr_ready", 32'(reqReady), 32'h2);
    check("wr_confirm_before", 32'(sramWriteConfirm), 32'h0);
    refMem[9'h040] = merge(refMem[9'h040], 16'hFFFF, 8'h03);
    rrModel = 1'b0;
    step();
    setReq(1, 1'b1, 1'b0, 9'h040, 16'h0, 8'h0);
    @(negedge clk);
    check("wr_confirm", 32'(sramWriteConfirm), 32'h1);
    check("wr_enable", 32'(sramWriteEnable), 32'h03);
    check("wr_addr", 32'(sramWriteAddr), 32'h040);
    check("wr_data", 32'(sramWriteData), 32'hFFFF);
    check("wrrd_ready", 32'(reqReady), 32'h2);
    sb.push_back('{v: 2'b10, d: refMem[9'h040], c: cyc + 3});
    rrModel = 1'b0;
    step();
    setReq(1, 1'b0, 1'b0, 9'h0, 16'h0, 8'h0);
    @(negedge clk);
    check("wr_confirm_after", 32'(sramWriteConfirm), 32'h0);
    check("wr_enable_after", 32'(sramWriteEnable), 32'h0);
    drain();

    // contention: both hold reads, each keeps its request until accepted
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      setReq(0, 1'b1, 1'b0, 9'(9'h100 + n0), 16'h0, 8'h0);
      setReq(1, 1'b1, 1'b0, 9'(9'h180 + n1), 16'h0, 8'h0);
      @(negedge clk);
      expG = rrModel ? 2'b10 : 2'b01;
      check("rr_grant", 32'(reqReady), 32'(expG));
      a = rrModel ? 9'(9'h180 + n1) : 9'(9'h100 + n0);
      sb.push_back('{v: expG, d: refMem[a], c: cyc + 3});
      if (rrModel) n1++; else n0++;
      rrModel = ~rrModel;
      step();
    end
    reqValid = '0;
    drain();

    // zero-mask write has no effect
    setReq(0, 1'b1, 1'b1, 9'h012, 16'h0000, 8'h00);
    @(negedge clk);
    check("zw_ready", 32'(reqReady), 32'h1);
    rrModel = 1'b1;
    step();
    setReq(0, 1'b1, 1'b0, 9'h012, 16'h0, 8'h0);
    @(negedge clk);
    check("zw_confirm", 32'(sramWriteConfirm), 32'h0);
    check("zw_enable", 32'(sramWriteEnable), 32'h0);
    check("zw_rd_ready", 32'(reqReady), 32'h1);
    sb.push_back('{v: 2'b01, d: refMem[9'h012], c: cyc + 3});
    step();
    reqValid = '0;
    drain();

    // reset while a read is in flight
    setReq(0, 1'b1, 1'b0, 9'h040, 16'h0, 8'h0);
    @(negedge clk);
    check("rst_rd_ready", 32'(reqReady), 32'h1);
    step();
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_reqReady", 32'(reqReady), 32'h0);
    step();
    reset_n = 1'b1;
    reqValid = '0;
    rrModel = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_confirm", 32'(sramWriteConfirm), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      check("rst_no_resp", 32'(respValid), 32'h0);
    end
    step();

    // pointer is back at requester 0
    setReq(0, 1'b1, 1'b0, 9'h033, 16'h0, 8'h0);
    setReq(1, 1'b1, 1'b0, 9'h044, 16'h0, 8'h0);
    @(negedge clk);
    check("rst_rr_grant", 32'(reqReady), 32'h1);
    sb.push_back('{v: 2'b01, d: refMem[9'h033], c: cyc + 3});
    step();
    reqValid = '0;
    drain();

    // readLatency=3 build: single read, then one read per cycle alternating requesters
    setReq3(0, 1'b1, 9'h012);
    @(negedge clk);
    check("l3_ready", 32'(reqReady3), 32'h1);
    sb3.push_back('{v: 2'b01, d: initWord(9'h012), c: cyc + 5});
    step();
    reqValid3 = '0;
    drain();
    for (int k = 0; k < 5; k++) begin
      reqValid3 = '0;
      setReq3(k % 2, 1'b1, 9'(9'h1F0 + k));
      @(negedge clk);
      expG = (k % 2 == 1) ? 2'b10 : 2'b01;
      check("l3_b2b_ready", 32'(reqReady3), 32'(expG));
      sb3.push_back('{v: expG, d: initWord(9'(9'h1F0 + k)), c: cyc + 5});
      step();
    end
    reqValid3 = '0;
    drain();
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("sb3_empty", sb3.size(), 0);
    check("final_idle", 32'(idle), 32'h1);
    check("final_idle3", 32'(idle3), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
